// File: rtl/ps2_pkg.sv
// Shared types and helpers for the device-side PS/2 engine.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    RX_WAIT,
    RX,
    ACK
  } state_t;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;
  // host-to-device samples: 8 data + parity + stop
  localparam int RX_BITS = 10;

  // Parity bit that makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizer chains for the sensed PS/2 clock and data lines.
// Flops reset to 1 so a reset never looks like a host request-to-send.
module ps2_line_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_sync,
  output logic data_sync
);

  logic [SYNC-1:0] clk_ff;
  logic [SYNC-1:0] data_ff;

  // Shift both line samples through SYNC flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_ff  <= '1;
      data_ff <= '1;
    end else begin
      clk_ff[0]  <= clk_in;
      data_ff[0] <= data_in;
      for (int i = 1; i < SYNC; i++) begin
        clk_ff[i]  <= clk_ff[i-1];
        data_ff[i] <= data_ff[i-1];
      end
    end
  end

  assign clk_sync  = clk_ff[SYNC-1];
  assign data_sync = data_ff[SYNC-1];

endmodule

// File: rtl/ps2_device.sv
// Device-side PS/2 engine: generates the PS/2 clock, sends device-to-host
// frames from a byte handshake, and receives/acknowledges host frames.
//
// state   | meaning
// IDLE    | lines released, watching for request-to-send or a held byte
// TX      | sending 11-bit frame; phase 0 = clk released, phase 1 = clk low
// RX_WAIT | request-to-send seen, half-period delay before first clock
// RX      | 10 clock pulses; phase 0 = clk low, phase 1 = clk high + sample
// ACK     | data held low across one more clock pulse, then result strobe
module ps2_device
  import ps2_pkg::*;
#(
  parameter int HALF     = 25,
  parameter int IDLE_MIN = 50,
  parameter int SYNC     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_in,
  input  logic       data_in,
  output logic       n_clk_out,
  output logic       n_data_out,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  localparam int CW = $clog2(HALF) + 1;
  localparam int IW = $clog2(IDLE_MIN + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(HALF - 1 - HALF / 2);
  localparam logic [IW-1:0] IDLE_FULL  = IW'(IDLE_MIN);
  localparam logic [3:0]    GUARD_LOAD = 4'(SYNC + 1);
  localparam logic [3:0]    TX_LAST    = 4'(FRAME_BITS - 1);
  localparam logic [3:0]    RX_LAST    = 4'(RX_BITS - 1);

  logic clk_sync, data_sync;

  ps2_line_sync #(.SYNC(SYNC)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (clk_in),
    .data_in   (data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync)
  );

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic [3:0]      bit_q, bit_d;
  logic [3:0]      guard_q, guard_d;
  logic [9:0]      rx_shift_q, rx_shift_d;
  logic [IW-1:0]   idle_q;
  logic [7:0]      hold_q;
  logic            held_q;
  logic            tx_done, rx_done, cnt_end;
  logic [10:0]     tx_frame;

  assign tx_frame = {1'b1, odd_parity(hold_q), hold_q, 1'b0};
  assign cnt_end  = (cnt_q == '0);
  assign tx_ready = ~held_q;
  assign busy     = (state_q != IDLE);

  // Line lows are combinational from state so a reset releases them at once.
  // The guard masks request-to-send detection for a few cycles after we let
  // go of a line, while the synchronized view still shows our own drive.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    guard_d    = guard_q;
    rx_shift_d = rx_shift_q;
    n_clk_out  = 1'b1;
    n_data_out = 1'b1;
    tx_done    = 1'b0;
    rx_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (guard_q != 4'd0) guard_d = guard_q - 4'd1;
        if (guard_q == 4'd0 && clk_sync && !data_sync) begin
          state_d = RX_WAIT;
          cnt_d   = CNT_LOAD;
        end else if (held_q && idle_q == IDLE_FULL) begin
          state_d = TX;
          cnt_d   = CNT_LOAD;
          phase_d = 1'b0;
          bit_d   = 4'd0;
        end
      end
      TX: begin
        n_data_out = tx_frame[bit_q];
        if (phase_q) n_clk_out = 1'b0;
        if (!cnt_end) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!phase_q) begin
          if (!clk_sync) begin
            state_d = IDLE;
            guard_d = GUARD_LOAD;
          end else begin
            phase_d = 1'b1;
            cnt_d   = CNT_LOAD;
          end
        end else if (bit_q == TX_LAST) begin
          state_d = IDLE;
          guard_d = GUARD_LOAD;
          tx_done = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          phase_d = 1'b0;
          cnt_d   = CNT_LOAD;
        end
      end
      RX_WAIT: begin
        if (cnt_end) begin
          state_d = RX;
          cnt_d   = CNT_LOAD;
          phase_d = 1'b0;
          bit_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX: begin
        if (!phase_q) begin
          n_clk_out = 1'b0;
          if (cnt_end) begin
            phase_d = 1'b1;
            cnt_d   = CNT_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end else if (cnt_q == CNT_SAMPLE && !clk_sync) begin
          state_d = IDLE;
          guard_d = GUARD_LOAD;
        end else begin
          if (cnt_q == CNT_SAMPLE) rx_shift_d = {data_sync, rx_shift_q[9:1]};
          if (cnt_end) begin
            phase_d = 1'b0;
            cnt_d   = CNT_LOAD;
            if (bit_q == RX_LAST) state_d = ACK;
            else bit_d = bit_q + 4'd1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ACK: begin
        n_data_out = 1'b0;
        if (!phase_q) n_clk_out = 1'b0;
        if (!cnt_end) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!phase_q) begin
          phase_d = 1'b1;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
          guard_d = GUARD_LOAD;
          rx_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and bit-timing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= 4'd0;
      guard_q    <= 4'd0;
      rx_shift_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      guard_q    <= guard_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Count clocks with both lines high, saturating; any low restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= '0;
    else if (clk_sync && data_sync) begin
      if (idle_q != IDLE_FULL) idle_q <= idle_q + 1'b1;
    end else idle_q <= '0;
  end

  // Holding register: byte stays held through inhibit aborts until sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      held_q <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      hold_q <= tx_data;
      held_q <= 1'b1;
    end else if (tx_done) begin
      held_q <= 1'b0;
    end
  end

  // Publish a received byte once the acknowledge completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= rx_done;
      rx_err   <= rx_done & ((rx_shift_q[8] != odd_parity(rx_shift_q[7:0])) | ~rx_shift_q[9]);
      if (rx_done) rx_data <= rx_shift_q[7:0];
    end
  end

endmodule

// File: tb/tb_ps2_device.sv
`timescale 1ns/1ns
module tb_ps2_device;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_clk_pull = 1'b0;
  logic       host_data_pull = 1'b0;
  logic       ps2_clk, ps2_data;
  logic       n_clk_out, n_data_out;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err, busy;

  int checks = 0;
  int passes = 0;
  int rdy_high = 0;

  assign ps2_clk  = n_clk_out & ~host_clk_pull;
  assign ps2_data = n_data_out & ~host_data_pull;

  always #500 clk = ~clk;

  ps2_device #(.HALF(25), .IDLE_MIN(50), .SYNC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_in     (ps2_clk),
    .data_in    (ps2_data),
    .n_clk_out  (n_clk_out),
    .n_data_out (n_data_out),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .busy       (busy)
  );

  task automatic wait_fall(output bit ok);
    int n;
    n = 0;
    while (ps2_clk !== 1'b1 && n < 3000) begin
      @(negedge clk); n++;
      if (tx_ready) rdy_high++;
    end
    while (ps2_clk !== 1'b0 && n < 3000) begin
      @(negedge clk); n++;
      if (tx_ready) rdy_high++;
    end
    ok = (ps2_clk === 1'b0);
  endtask

  task automatic measure_low(output int len);
    len = 0;
    while (ps2_clk === 1'b0 && len < 3000) begin
      len++;
      if (tx_ready) rdy_high++;
      @(negedge clk);
    end
  endtask

  task automatic host_receive(output logic [10:0] fr, output int mn, output int mx, output bit ok);
    bit f;
    int len;
    fr = '0; mn = 9999; mx = 0; ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wait_fall(f);
      if (!f) begin ok = 1'b0; break; end
      fr[i] = ps2_data;
      measure_low(len);
      if (len < mn) mn = len;
      if (len > mx) mx = len;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); tx_data = b; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
  endtask

  task automatic host_send(input logic [7:0] b, input logic par, input logic collide,
                           output bit ok, output bit ack_low, output int vcnt,
                           output logic [7:0] rdata, output logic rerr);
    logic [9:0] bits;
    bit f;
    int n;
    bits = {1'b1, par, b};
    ok = 1'b1; ack_low = 1'b0; vcnt = 0; rdata = 8'hxx; rerr = 1'bx;
    @(negedge clk); host_clk_pull = 1'b1;
    repeat (100) @(negedge clk);
    host_data_pull = 1'b1;
    repeat (5) @(negedge clk);
    host_clk_pull = 1'b0;
    if (collide) begin
      tx_data = 8'hFF; tx_valid = 1'b1;
      @(negedge clk); tx_valid = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      wait_fall(f);
      if (!f) ok = 1'b0;
      host_data_pull = ~bits[i];
    end
    wait_fall(f);
    if (!f) ok = 1'b0;
    ack_low = (ps2_data === 1'b0);
    n = 0;
    while (vcnt == 0 && n < 300) begin
      @(negedge clk); n++;
      if (rx_valid === 1'b1) begin vcnt++; rdata = rx_data; rerr = rx_err; end
    end
    repeat (3) begin
      @(negedge clk);
      if (rx_valid === 1'b1) vcnt++;
    end
  endtask

  task automatic count_lows(input int cycles, output int lows);
    lows = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ps2_clk !== 1'b1) lows++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({n_clk_out, n_data_out, tx_ready, rx_valid, rx_err, busy, rx_data} !== {6'b111000, 8'h00})
      $display("FAIL reset_values: got %b_%h required 111000_00",
               {n_clk_out, n_data_out, tx_ready, rx_valid, rx_err, busy}, rx_data);
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_tx;
    logic [10:0] fr; int mn, mx; bit ok;
    rdy_high = 0;
    send_byte(8'hA5);
    host_receive(fr, mn, mx, ok);
    checks++;
    if (!ok) $display("FAIL tx_a5_timeout: frame incomplete");
    else passes++;
    checks++;
    if (fr !== {1'b1, 1'b1, 8'hA5, 1'b0}) $display("FAIL tx_a5_frame: got %b required %b", fr, {1'b1, 1'b1, 8'hA5, 1'b0});
    else passes++;
    checks++;
    if (mn != 25 || mx != 25) $display("FAIL tx_a5_low_len: got min %0d max %0d required 25", mn, mx);
    else passes++;
    checks++;
    if (rdy_high != 0) $display("FAIL tx_a5_ready_low: tx_ready high on %0d frame cycles, required 0", rdy_high);
    else passes++;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL tx_a5_ready_after: got %b required 1", tx_ready);
    else passes++;
  endtask

  task automatic test_inhibit;
    logic [10:0] fr; int mn, mx, len, n, lows; bit ok, f;
    ok = 1'b1;
    send_byte(8'h84);
    for (int i = 0; i < 4; i++) begin
      wait_fall(f);
      if (!f) ok = 1'b0;
      measure_low(len);
    end
    host_clk_pull = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (!ok || {n_clk_out, n_data_out, busy, tx_ready} !== 4'b1100)
      $display("FAIL inhibit_release: got ok=%0d lines/busy/ready %b required 1100", ok, {n_clk_out, n_data_out, busy, tx_ready});
    else passes++;
    host_clk_pull = 1'b0;
    n = 0;
    while (n_data_out !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (n < 50 || n > 60) $display("FAIL inhibit_retry_delay: got %0d cycles required 50..60", n);
    else passes++;
    host_receive(fr, mn, mx, ok);
    checks++;
    if (!ok || fr !== {1'b1, 1'b1, 8'h84, 1'b0})
      $display("FAIL inhibit_frame: got ok=%0d %b required %b", ok, fr, {1'b1, 1'b1, 8'h84, 1'b0});
    else passes++;
    count_lows(400, lows);
    checks++;
    if (lows != 0 || tx_ready !== 1'b1)
      $display("FAIL inhibit_once: got %0d extra low cycles ready=%b required 0 and 1", lows, tx_ready);
    else passes++;
  endtask

  task automatic test_rx(input logic [7:0] b, input logic par, input logic exp_err, input string nm);
    bit ok, ack; int v; logic [7:0] d; logic e;
    host_send(b, par, 1'b0, ok, ack, v, d, e);
    checks++;
    if (!ok || !ack) $display("FAIL %s_ack: got ok=%0d ack_low=%0d required 1 1", nm, ok, ack);
    else passes++;
    checks++;
    if (v != 1) $display("FAIL %s_valid_width: got %0d cycles required 1", nm, v);
    else passes++;
    checks++;
    if (d !== b || e !== exp_err) $display("FAIL %s_result: got data %h err %b required %h %b", nm, d, e, b, exp_err);
    else passes++;
  endtask

  task automatic test_collision;
    bit ok, ack; int v, mn, mx; logic [7:0] d; logic e; logic [10:0] fr;
    host_send(8'h00, 1'b1, 1'b1, ok, ack, v, d, e);
    checks++;
    if (!ok || !ack || v != 1 || d !== 8'h00 || e !== 1'b0)
      $display("FAIL collide_rx: got ok=%0d ack=%0d v=%0d data %h err %b required 1 1 1 00 0", ok, ack, v, d, e);
    else passes++;
    checks++;
    if (tx_ready !== 1'b0) $display("FAIL collide_held: got tx_ready %b required 0", tx_ready);
    else passes++;
    host_receive(fr, mn, mx, ok);
    checks++;
    if (!ok || fr !== {1'b1, 1'b1, 8'hFF, 1'b0})
      $display("FAIL collide_tx: got ok=%0d %b required %b", ok, fr, {1'b1, 1'b1, 8'hFF, 1'b0});
    else passes++;
  endtask

  task automatic test_reset_mid_tx;
    int len, lows; bit ok, f;
    ok = 1'b1;
    send_byte(8'h00);
    for (int i = 0; i < 6; i++) begin
      wait_fall(f);
      if (!f) ok = 1'b0;
      measure_low(len);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || n_data_out !== 1'b0) $display("FAIL rst_mid_setup: got ok=%0d n_data_out %b required 1 0", ok, n_data_out);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if ({n_clk_out, n_data_out, tx_ready, busy} !== 4'b1110)
      $display("FAIL rst_mid_release: got %b required 1110", {n_clk_out, n_data_out, tx_ready, busy});
    else passes++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    count_lows(600, lows);
    checks++;
    if (lows != 0 || tx_ready !== 1'b1 || rx_valid !== 1'b0)
      $display("FAIL rst_mid_no_resume: got %0d low cycles ready=%b rx_valid=%b required 0 1 0", lows, tx_ready, rx_valid);
    else passes++;
  endtask

  initial begin
    #90_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tx();
    test_inhibit();
    // CA has four ones, so odd parity is 1.
    test_rx(8'hCA, 1'b1, 1'b0, "rx_ca");
    // 02 has one one; parity 1 makes the total even, which is an error.
    test_rx(8'h02, 1'b1, 1'b1, "rx_bad_par");
    test_collision();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
